// File: rtl/multdiv_div_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_div_pkg
//   Shared definitions for the sequential multiply/divide family.
//   Holds the default operand width and iteration count, the width of the
//   iteration counter, and the sequencer state encoding. The divider imports
//   these today, and the multiplier sequencer is expected to reuse them.
// ---------------------------------------------------------------------------
package multdiv_div_pkg;

    // Default operand width and number of shift/subtract steps per operation.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_ITER  = 32;

    // Iteration counter width. A 5-bit counter covers up to 32 iterations.
    localparam int CNT_W = 5;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Counter load value for a given iteration count. The counter runs from
    // iter-1 down to 0, so one RUN cycle is spent per count value.
    function automatic logic [CNT_W-1:0] iter_load(input int iter);
        return CNT_W'(iter - 1);
    endfunction

endpackage : multdiv_div_pkg

// File: rtl/multdiv_div_counter.sv
// ---------------------------------------------------------------------------
// down_counter_5
//   5-bit loadable down-counter that paces the divider iterations.
//   Ports:
//     clock      - rising-edge clock
//     clr_n      - asynchronous active-low clear (count forced to 0)
//     load       - load load_value (takes priority over en)
//     en         - decrement by one; the count stops at 0
//     load_value - value taken on load
//     tc         - terminal count, high while the count is 0
// ---------------------------------------------------------------------------
module down_counter_5
    import multdiv_div_pkg::*;
(
    input  logic             clock,
    input  logic             clr_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the netlist.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign tc = (count_q == '0);

endmodule : down_counter_5

// File: rtl/multdiv_div.sv
// ---------------------------------------------------------------------------
// multdiv_div
//   Sequential signed divider using restoring shift/subtract on magnitudes,
//   followed by a sign-correction step. One iteration per clock.
//
//   Timing: the start edge captures the operands. The next edge launches the
//   division. RUN lasts ITER cycles and FIX lasts one cycle. DONE then
//   pulses data_ready for one cycle. A zero divisor skips RUN and FIX and
//   goes straight to DONE with the exception flag set.
//
//   Ports:
//     clock      - rising-edge clock
//     clr_n      - asynchronous active-low reset
//     start      - request a division; sampled on the rising edge in IDLE
//     dividend   - signed numerator, sampled with start
//     divisor    - signed denominator, sampled with start
//     quotient   - signed quotient, truncated toward zero
//     remainder  - signed remainder, same sign as the dividend
//     busy       - high in RUN and FIX
//     data_ready - one-cycle pulse when the results are valid
//     exception  - divide-by-zero flag, held until the next accepted start
// ---------------------------------------------------------------------------
module multdiv_div
    import multdiv_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = DEF_ITER
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             data_ready,
    output logic             exception
);

    div_state_t state_q, state_d;

    // The operands were captured and the division launches on the next edge.
    logic             pend_q;

    logic             dvd_neg_q;
    logic             dvs_neg_q;
    logic             dvs_zero_q;
    logic [WIDTH-1:0] dvs_mag_q;
    logic [WIDTH-1:0] part_r_q;   // partial remainder
    logic [WIDTH-1:0] part_q_q;   // dividend bits shifting out, quotient bits shifting in

    logic             tc;
    logic             accept;
    logic             launch;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] q_fixed;
    logic [WIDTH-1:0] r_fixed;

    // A start is taken only in IDLE with nothing pending. Starts in RUN, FIX
    // or DONE fall through untouched.
    assign accept = (state_q == IDLE) && start && !pend_q;
    assign launch = (state_q == IDLE) && pend_q;

    // -----------------------------------------------------------------------
    // Iteration counter
    // -----------------------------------------------------------------------
    down_counter_5 u_iter_cnt (
        .clock      (clock),
        .clr_n      (clr_n),
        .load       (launch && !dvs_zero_q),
        .en         ((state_q == RUN) && !tc),
        .load_value (iter_load(ITER)),
        .tc         (tc)
    );

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch) state_d = dvs_zero_q ? DONE : RUN;
            RUN:  if (tc)     state_d = FIX;   // count 0 marks the last step
            FIX:              state_d = DONE;
            DONE:             state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == RUN) || (state_q == FIX);
    assign data_ready = (state_q == DONE);

    // -----------------------------------------------------------------------
    // Datapath combinational terms
    // -----------------------------------------------------------------------
    always_comb begin
        // The most negative value maps to itself. Read as unsigned, that is
        // the correct magnitude.
        dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
        dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

        // Restoring step: shift in the next dividend bit and try to subtract.
        shifted = {part_r_q, part_q_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_mag_q};
        fits    = !diff[WIDTH];
        step_r  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        step_q  = {part_q_q[WIDTH-2:0], fits};

        // Sign correction. The quotient sign follows the XOR of the operand
        // signs, and the remainder sign follows the dividend.
        q_fixed = (dvd_neg_q ^ dvs_neg_q) ? -part_q_q : part_q_q;
        r_fixed = dvd_neg_q ? -part_r_q : part_r_q;
    end

    // -----------------------------------------------------------------------
    // Datapath registers. The visible outputs change only on the edge that
    // enters DONE, so partial results never reach the ports.
    // -----------------------------------------------------------------------
    // NOTE: the datapath registers are reset along with the control
    // registers, because an aborted division must leave zeros on the
    // outputs. They are flops, not a memory array, so the reset costs
    // nothing.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            pend_q     <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            dvs_zero_q <= 1'b0;
            dvs_mag_q  <= '0;
            part_r_q   <= '0;
            part_q_q   <= '0;
            quotient   <= '0;
            remainder  <= '0;
            exception  <= 1'b0;
        end else begin
            if (accept) begin
                pend_q     <= 1'b1;
                dvd_neg_q  <= dividend[WIDTH-1];
                dvs_neg_q  <= divisor[WIDTH-1];
                dvs_zero_q <= (divisor == '0);
                dvs_mag_q  <= dvs_mag;
                part_r_q   <= '0;
                part_q_q   <= dvd_mag;
                exception  <= 1'b0;
            end else if (launch) begin
                pend_q <= 1'b0;
                if (dvs_zero_q) begin
                    quotient  <= '0;
                    remainder <= '0;
                    exception <= 1'b1;
                end
            end

            if (state_q == RUN) begin
                part_r_q <= step_r;
                part_q_q <= step_q;
            end

            if (state_q == FIX) begin
                quotient  <= q_fixed;
                remainder <= r_fixed;
            end
        end
    end

endmodule : multdiv_div

// File: tb/tb_multdiv_div.sv
// ---------------------------------------------------------------------------
// tb_multdiv_div
//   Scoreboard bench for multdiv_div. The stimulus process issues directed
//   divisions and queues the hand-computed results. The monitor process
//   compares each data_ready pulse against the queue head. It also checks
//   latency, the busy cycle count, output hold between results, and the
//   zero outputs under reset.
// ---------------------------------------------------------------------------
module tb_multdiv_div;

    logic        clock = 1'b0;
    logic        clr_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        data_ready;
    logic        exception;

    multdiv_div #(.WIDTH(32), .ITER(32)) dut (
        .clock      (clock),
        .clr_n      (clr_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .data_ready (data_ready),
        .exception  (exception)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          lat;
        int          bsy;
        int          start_cyc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Issue one division. The start edge is the posedge inside this task.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ex, input int lat, input int bsy,
                         input string nm);
        @(negedge clock);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1;
        exp_q.push_back('{q: eq, r: er, exc: ex, lat: lat, bsy: bsy, start_cyc: cyc});
        name_q.push_back(nm);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;   // operands must already be captured
        divisor  = 32'hDEAD_BEEF;
    endtask

    // The monitor pops the queue, or drops a stale entry once its watchdog
    // expires, so this wait always ends.
    task automatic wait_done();
        while (exp_q.size() != 0) begin
            @(negedge clock);
            #1;
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------------
    initial begin
        logic [31:0] held_q;
        logic [31:0] held_r;
        int          busy_cnt;
        exp_t        e;
        string       nm;
        held_q   = '0;
        held_r   = '0;
        busy_cnt = 0;
        forever begin
            @(negedge clock);
            if (!clr_n) begin
                check("rst_quotient",   quotient,                 32'd0);
                check("rst_remainder",  remainder,                32'd0);
                check("rst_busy",       {31'd0, busy},            32'd0);
                check("rst_data_ready", {31'd0, data_ready},      32'd0);
                check("rst_exception",  {31'd0, exception},       32'd0);
                exp_q.delete();
                name_q.delete();
                held_q   = '0;
                held_r   = '0;
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (data_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_data_ready", {31'd0, data_ready}, 32'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        check({nm, "_quotient"},  quotient,                 e.q);
                        check({nm, "_remainder"}, remainder,                e.r);
                        check({nm, "_exception"}, {31'd0, exception},       {31'd0, e.exc});
                        check({nm, "_latency"},   32'(cyc - e.start_cyc),   32'(e.lat));
                        check({nm, "_busy_cycles"}, 32'(busy_cnt),          32'(e.bsy));
                        held_q = e.q;
                        held_r = e.r;
                    end
                    busy_cnt = 0;
                end else begin
                    check("hold_quotient",  quotient,  held_q);
                    check("hold_remainder", remainder, held_r);
                    if (exp_q.size() != 0 && (cyc - exp_q[0].start_cyc) > 100) begin
                        check({name_q[0], "_timeout_latency"},
                              32'(cyc - exp_q[0].start_cyc), 32'(exp_q[0].lat));
                        void'(exp_q.pop_front());
                        void'(name_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        clr_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1 clr_n = 1'b1;

        issue(32'd100,          32'd7,          32'd14,         32'd2,          1'b0, 34, 33, "p100_p7");
        wait_done();
        issue(-32'sd100,        32'd7,          -32'sd14,       -32'sd2,        1'b0, 34, 33, "n100_p7");
        wait_done();
        issue(32'd100,          -32'sd7,        -32'sd14,       32'd2,          1'b0, 34, 33, "p100_n7");
        wait_done();
        issue(-32'sd100,        -32'sd7,        32'd14,         -32'sd2,        1'b0, 34, 33, "n100_n7");
        wait_done();
        issue(32'd7,            32'd100,        32'd0,          32'd7,          1'b0, 34, 33, "small_over_big");
        wait_done();
        issue(32'h7FFF_FFFF,    32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 34, 33, "maxpos_by_1");
        wait_done();
        issue(-32'sd1,          32'd2,          32'd0,          32'hFFFF_FFFF,  1'b0, 34, 33, "n1_p2");
        wait_done();
        issue(32'h8000_0000,    -32'sd1,        32'h8000_0000,  32'd0,          1'b0, 34, 33, "overflow");
        wait_done();

        // Divide by zero: a short path, and the flag holds afterwards.
        issue(32'd5,            32'd0,          32'd0,          32'd0,          1'b1, 1,  0,  "div_by_zero");
        wait_done();
        repeat (3) @(negedge clock);
        check("div_by_zero_exception_held", {31'd0, exception}, 32'd1);

        // The flag clears on the next accepted start.
        issue(32'd20,           32'd6,          32'd3,          32'd2,          1'b0, 34, 33, "after_zero");
        wait_done();

        // A start pulsed mid-run must be ignored.
        issue(32'd100,          32'd7,          32'd14,         32'd2,          1'b0, 34, 33, "busy_start_ignored");
        repeat (9) @(posedge clock);
        #1;
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done();

        // A start in the DONE cycle is ignored. The monitor flags an extra
        // data_ready if it is wrongly taken, and the next result would be
        // corrupted.
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd7;
        @(posedge clock);
        #1 start = 1'b0;
        issue(32'd9,            32'd3,          32'd3,          32'd0,          1'b0, 34, 33, "after_done");
        wait_done();

        // Reset mid-division aborts cleanly, and the next start works.
        issue(32'd100,          32'd7,          32'd14,         32'd2,          1'b0, 34, 33, "aborted");
        repeat (15) @(posedge clock);
        #1 clr_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 clr_n = 1'b1;
        issue(32'd50,           32'd5,          32'd10,         32'd0,          1'b0, 34, 33, "after_reset");
        wait_done();

        repeat (40) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule : tb_multdiv_div
